// File: rtl/regfile_bist_if.sv
// Register-file bus between the BIST sequencer (master) and the register file (slave).
interface regfile_bist_if;
  logic [31:0] write_data;
  logic [4:0]  write_register;
  logic        reg_write;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  modport master (
    output write_data,
    output write_register,
    output reg_write,
    output read_register1,
    output read_register2,
    input  read_data1,
    input  read_data2
  );

  modport slave (
    input  write_data,
    input  write_register,
    input  reg_write,
    input  read_register1,
    input  read_register2,
    output read_data1,
    output read_data2
  );
endinterface

// File: rtl/regfile_bist.sv
// Built-in self-test sequencer for a 32x32 register file. Runs three write/read-back
// phases (pattern, inverted pattern, suppressed write) and latches the first mismatch.
module regfile_bist #(
  parameter logic [31:0] Seed       = 32'hA5C3_0F1E,
  parameter bit          ZeroReg    = 1'b1,
  parameter bit          StopOnFail = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [4:0]            fail_addr_o,
  output logic [1:0]            fail_port_o,
  output logic [1:0]            fail_phase_o,
  regfile_bist_if.master        rf
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  r_q, r_d;
  logic [1:0]  phase_q, phase_d;
  logic        pass_q, pass_d;
  logic [4:0]  fail_addr_q, fail_addr_d;
  logic [1:0]  fail_port_q, fail_port_d;
  logic [1:0]  fail_phase_q, fail_phase_d;

  logic [31:0] pat;
  logic [31:0] exp1, exp2;
  logic [1:0]  mis;

  // Value a healthy register file must hold at addr during the given phase.
  function automatic logic [31:0] exp_of(logic [4:0] addr, logic [1:0] phase);
    logic [31:0] p;
    p = Seed + {27'b0, addr};
    if (ZeroReg && addr == 5'd0) return 32'd0;
    return (phase == 2'd0) ? p : ~p;
  endfunction

  assign pat  = Seed + {27'b0, r_q};
  assign exp1 = exp_of(r_q, phase_q);
  assign exp2 = exp_of(~r_q, phase_q);  // ~r == 31 - r for a 5-bit index
  assign mis  = {rf.read_data2 != exp2, rf.read_data1 != exp1};

  // State, index, phase and first-failure registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      r_q          <= 5'd0;
      phase_q      <= 2'd0;
      pass_q       <= 1'b1;
      fail_addr_q  <= 5'd0;
      fail_port_q  <= 2'd0;
      fail_phase_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      phase_q      <= phase_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_port_q  <= fail_port_d;
      fail_phase_q <= fail_phase_d;
    end
  end

  // Next-state: sequencing through phases and first-mismatch capture.
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    phase_d      = phase_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_port_d  = fail_port_q;
    fail_phase_d = fail_phase_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d      = StWrite;
          r_d          = 5'd0;
          phase_d      = 2'd0;
          pass_d       = 1'b1;
          fail_addr_d  = 5'd0;
          fail_port_d  = 2'd0;
          fail_phase_d = 2'd0;
        end
      end
      StWrite: begin
        r_d = r_q + 5'd1;
        if (r_q == 5'd31) state_d = StRead;
      end
      StRead: begin
        r_d = r_q + 5'd1;
        if (mis != 2'b00 && pass_q) begin
          pass_d       = 1'b0;
          fail_addr_d  = r_q;
          fail_port_d  = mis;
          fail_phase_d = phase_q;
        end
        if (mis != 2'b00 && StopOnFail) begin
          state_d = StDone;
        end else if (r_q == 5'd31) begin
          if (phase_q == 2'd2) begin
            state_d = StDone;
          end else begin
            state_d = StWrite;
            phase_d = phase_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus drive decoded from registered state only; reset forces IDLE, so reg_write drops at once.
  always_comb begin
    rf.write_data     = 32'd0;
    rf.write_register = 5'd0;
    rf.reg_write      = 1'b0;
    rf.read_register1 = 5'd0;
    rf.read_register2 = 5'd0;
    if (state_q == StWrite) begin
      rf.write_register = r_q;
      rf.reg_write      = (phase_q != 2'd2);
      // Phase 2 drives a junk value that must not land.
      rf.write_data     = (phase_q == 2'd1) ? ~pat : pat;
    end else if (state_q == StRead) begin
      rf.read_register1 = r_q;
      rf.read_register2 = ~r_q;
    end
  end

  assign done_o       = (state_q == StDone);
  assign pass_o       = pass_q;
  assign fail_addr_o  = fail_addr_q;
  assign fail_port_o  = fail_port_q;
  assign fail_phase_o = fail_phase_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench for regfile_bist with a behavioural register file that can be
// configured as healthy or with specific faults.
module tb_regfile_bist;

  localparam logic [31:0] SEED = 32'hA5C3_0F1E;

  typedef enum int {MIdeal, MConst42, MIgnoreWe, MReg0W} mode_e;

  logic        clk;
  logic        rst;
  logic        start;
  logic        done;
  logic        pass;
  logic [4:0]  fail_addr;
  logic [1:0]  fail_port;
  logic [1:0]  fail_phase;
  mode_e       mode;
  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  regfile_bist_if rf ();

  regfile_bist dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .done_o       (done),
    .pass_o       (pass),
    .fail_addr_o  (fail_addr),
    .fail_port_o  (fail_port),
    .fail_phase_o (fail_phase),
    .rf           (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model with selectable faults.
  always @(posedge clk) begin
    if (rf.reg_write || mode == MIgnoreWe) begin
      if (rf.write_register != 5'd0 || mode == MReg0W) regs[rf.write_register] <= rf.write_data;
    end
  end

  always_comb begin
    rf.read_data1 = 32'd0;
    rf.read_data2 = 32'd0;
    if (mode == MConst42) begin
      rf.read_data1 = 32'd42;
      rf.read_data2 = 32'd42;
    end else begin
      rf.read_data1 = (rf.read_register1 == 5'd0 && mode != MReg0W) ? 32'd0 : regs[rf.read_register1];
      rf.read_data2 = (rf.read_register2 == 5'd0 && mode != MReg0W) ? 32'd0 : regs[rf.read_register2];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pulse start, then count edges after the sampling edge until done (bounded).
  task automatic do_run(output int edges);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_cleared_after_start", {31'd0, done}, 32'd0);
    edges = 0;
    while (!done && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  typedef struct {
    mode_e      mode;
    int         edges;
    logic       pass;
    logic [1:0] port;
    logic [1:0] phase;
    logic [4:0] addr;
  } vec_t;

  vec_t vecs [5];
  int   n;

  initial begin
    vecs[0] = '{MIdeal,    192, 1'b1, 2'b00, 2'd0, 5'd0};
    vecs[1] = '{MConst42,   33, 1'b0, 2'b11, 2'd0, 5'd0};
    vecs[2] = '{MIgnoreWe, 161, 1'b0, 2'b10, 2'd2, 5'd0};
    vecs[3] = '{MReg0W,     33, 1'b0, 2'b01, 2'd0, 5'd0};
    vecs[4] = '{MIdeal,    192, 1'b1, 2'b00, 2'd0, 5'd0};

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    mode  = MIdeal;
    start = 1'b0;
    rst   = 1'b1;
    #3;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd1);
    chk("rst_fail_addr", {27'd0, fail_addr}, 32'd0);
    chk("rst_fail_port", {30'd0, fail_port}, 32'd0);
    chk("rst_fail_phase", {30'd0, fail_phase}, 32'd0);
    chk("rst_reg_write", {31'd0, rf.reg_write}, 32'd0);
    chk("rst_write_data", rf.write_data, 32'd0);
    chk("rst_read_register2", {27'd0, rf.read_register2}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean run with bus checks at phase boundaries and a start re-pulse at edge 100.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("e0_write_register", {27'd0, rf.write_register}, 32'd0);
    chk("e0_write_data", rf.write_data, SEED);
    chk("e0_reg_write", {31'd0, rf.reg_write}, 32'd1);
    for (int e = 1; e <= 192; e++) begin
      if (e == 100) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e == 5) chk("e5_write_data", rf.write_data, SEED + 32'd5);
      if (e == 32) begin
        chk("e32_reg_write", {31'd0, rf.reg_write}, 32'd0);
        chk("e32_read_register1", {27'd0, rf.read_register1}, 32'd0);
        chk("e32_read_register2", {27'd0, rf.read_register2}, 32'd31);
      end
      if (e == 64) begin
        chk("e64_write_data", rf.write_data, ~SEED);
        chk("e64_reg_write", {31'd0, rf.reg_write}, 32'd1);
      end
      if (e == 128) begin
        chk("e128_write_data", rf.write_data, SEED);
        chk("e128_reg_write", {31'd0, rf.reg_write}, 32'd0);
      end
      if (e == 191) chk("e191_done", {31'd0, done}, 32'd0);
    end
    chk("e192_done", {31'd0, done}, 32'd1);
    chk("e192_pass", {31'd0, pass}, 32'd1);
    chk("e192_fail_port", {30'd0, fail_port}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", {31'd0, done}, 32'd1);
    chk("done_reg_write", {31'd0, rf.reg_write}, 32'd0);

    // Fault table; each run starts from DONE.
    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      do_run(n);
      chk($sformatf("v%0d_edges", i), n, vecs[i].edges);
      chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].pass});
      chk($sformatf("v%0d_fail_port", i), {30'd0, fail_port}, {30'd0, vecs[i].port});
      chk($sformatf("v%0d_fail_phase", i), {30'd0, fail_phase}, {30'd0, vecs[i].phase});
      chk($sformatf("v%0d_fail_addr", i), {27'd0, fail_addr}, {27'd0, vecs[i].addr});
    end

    // Reset mid-write: reg_write must drop immediately.
    mode = MIdeal;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    chk("e70_reg_write", {31'd0, rf.reg_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_reg_write", {31'd0, rf.reg_write}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_pass", {31'd0, pass}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_run(n);
    chk("after_rst_edges", n, 32'd192);
    chk("after_rst_pass", {31'd0, pass}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
